alu_nbit_seq: RTL and testbench

- Parametrised WIDTH-bit ALU and the successor to the 1-bit ALU slice.
- Keeps the Ainvert/Binvert/cy_in operand-conditioning scheme and the AND/OR/ADD/SLT operations.
- Adds registered outputs, a start/done handshake, and a multi-cycle unsigned shift-add multiply.
- Sits in the datapath execute stage, under a controller that issues one operation at a time.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_adder_nbit.sv | 28 ++
 rtl/alu_nbit_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_nbit_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-codes and controller state encoding for alu_nbit_seq.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_adder_nbit.sv
// Parametrised ripple-carry adder with carry-out and signed-overflow flag.
module alu_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic c;

  // Bit-serial carry chain, LSB first
  always_comb begin
    sum = {WIDTH{1'b0}};
    c   = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU: AND/OR/ADD/SLT in one cycle, unsigned shift-add MUL over WIDTH cycles.
// Define ALU_SAT_EN to make ADD saturate on signed overflow instead of wrapping.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Ainvert,
  input  logic             Binvert,
  input  logic             cy_in,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] a_c, b_c, add_a, add_b, add_sum, add_res;
  logic             add_cin, add_cout, add_ovf, upd;

  assign a_c = Ainvert ? ~a : a;
  assign b_c = Binvert ? ~b : b;

  alu_adder_nbit #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // Adder sharing: MUL accumulate, SLT subtraction, or conditioned ADD operands
  always_comb begin
    if (state_q == ST_MUL) begin
      add_a   = hi_q;
      add_b   = lo_q[0] ? mcand_q : {WIDTH{1'b0}};
      add_cin = 1'b0;
    end else if (op == OP_SLT) begin
      add_a   = a;
      add_b   = ~b;
      add_cin = 1'b1;
    end else begin
      add_a   = a_c;
      add_b   = b_c;
      add_cin = cy_in;
    end
  end

  // ADD result, optionally clamped toward the sign of a' on overflow
  always_comb begin
    add_res = add_sum;
`ifdef ALU_SAT_EN
    if (add_ovf) begin
      add_res = a_c[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      add_res = add_sum;
    end
`endif
  end

  // Next-state and output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mcand_d     = mcand_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    upd         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          upd         = 1'b1;
          done_d      = 1'b1;
          result_hi_d = {WIDTH{1'b0}};
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
          case (op)
            OP_AND: result_d = a_c & b_c;
            OP_OR:  result_d = a_c | b_c;
            OP_ADD: begin
              result_d = add_res;
              cout_d   = add_cout;
              ovf_d    = add_ovf;
            end
            OP_SLT: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
              cout_d   = add_cout;
            end
            OP_MUL: begin
              // Operands are latched; visible outputs stay put until the product lands
              upd         = 1'b0;
              done_d      = 1'b0;
              result_hi_d = result_hi_q;
              cout_d      = cout_q;
              ovf_d       = ovf_q;
              mcand_d     = a;
              lo_d        = b;
              hi_d        = {WIDTH{1'b0}};
              cnt_d       = {CNT_W{1'b0}};
              busy_d      = 1'b1;
              state_d     = ST_MUL;
            end
            default: result_d = {WIDTH{1'b0}};
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (cnt_q != CNT_LAST) begin
          hi_d   = {add_cout, add_sum[WIDTH-1:1]};
          lo_d   = {add_sum[0], lo_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = (cnt_q + CNT_ONE) != CNT_LAST;
        end else begin
          upd         = 1'b1;
          result_d    = lo_q;
          result_hi_d = hi_q;
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    if (upd) begin
      zero_d = ~|{result_hi_d, result_d};
    end else begin
      zero_d = zero_q;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      result_hi_q <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mcand_q     <= mcand_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero_flag = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed plus randomized bench for alu_nbit_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic         clk, reset, start, Ainvert, Binvert, cy_in;
  logic [W-1:0] a, b, result, result_hi;
  logic [2:0]   op;
  logic         zero_flag, cout, overflow, busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .Ainvert   (Ainvert),
    .Binvert   (Binvert),
    .cy_in     (cy_in),
    .op        (op),
    .result    (result),
    .result_hi (result_hi),
    .zero_flag (zero_flag),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour computed with plain integer arithmetic
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic ai, input logic bi, input logic ci);
    exp_t         e;
    logic [W-1:0] ac, bc;
    int           u, s;
    logic [15:0]  p;
    e  = '0;
    ac = ai ? ~xa : xa;
    bc = bi ? ~xb : xb;
    case (o)
      3'd0: e.res = ac & bc;
      3'd1: e.res = ac | bc;
      3'd2: begin
        u     = int'(ac) + int'(bc) + int'(ci);
        s     = int'($signed(ac)) + int'($signed(bc)) + int'(ci);
        e.res = u[7:0];
        e.c   = (u > 255);
        e.v   = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
        if (e.v) e.res = (s > 127) ? 8'h7F : 8'h80;
`endif
      end
      3'd3: begin
        e.res = {7'd0, ($signed(xa) < $signed(xb))};
        e.c   = (xa >= xb);
      end
      3'd4: begin
        p     = {8'd0, xa} * {8'd0, xb};
        e.res = p[7:0];
        e.hi  = p[15:8];
      end
      default: e.res = 8'h00;
    endcase
    e.z = ({e.hi, e.res} == 16'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic d, input logic bz);
    chk({tag, "_result"}, 32'(result), 32'(e.res));
    chk({tag, "_result_hi"}, 32'(result_hi), 32'(e.hi));
    chk({tag, "_zero"}, 32'(zero_flag), 32'(e.z));
    chk({tag, "_cout"}, 32'(cout), 32'(e.c));
    chk({tag, "_ovf"}, 32'(overflow), 32'(e.v));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
    chk({tag, "_done"}, 32'(done), 32'(d));
  endtask

  task automatic run_alu(input string tag, input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ai, input logic bi, input logic ci);
    exp_t e;
    e       = model(o, xa, xb, ai, bi, ci);
    op      = o;
    a       = xa;
    b       = xb;
    Ainvert = ai;
    Binvert = bi;
    cy_in   = ci;
    start   = 1'b1;
    tick;
    start = 1'b0;
    check_out(tag, e, 1'b1, 1'b0);
    a  = W'($urandom);
    b  = W'($urandom);
    op = 3'($urandom);
    tick;
    check_out({tag, "_hold"}, e, 1'b0, 1'b0);
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    int   cyc, busy_n;
    e     = model(3'd4, xa, xb, 1'b0, 1'b0, 1'b0);
    op    = 3'd4;
    a     = xa;
    b     = xb;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_busy_first"}, 32'(busy), 32'd1);
    chk({tag, "_done_first"}, 32'(done), 32'd0);
    busy_n = 1;
    cyc    = 0;
    a      = W'($urandom);
    b      = W'($urandom);
    while (done !== 1'b1 && cyc < 30) begin
      if (cyc == 2) begin
        start = 1'b1;
        op    = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      tick;
      cyc++;
      if (busy === 1'b1) busy_n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd9);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check_out(tag, e, 1'b1, 1'b0);
    tick;
    check_out({tag, "_hold"}, e, 1'b0, 1'b0);
  endtask

  task automatic run_any(input string tag, input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ai, input logic bi, input logic ci);
    if (o == 3'd4) run_mul(tag, xa, xb);
    else run_alu(tag, o, xa, xb, ai, bi, ci);
  endtask

  initial begin
    exp_t e0, e1;
    reset   = 1'b1;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    op      = 3'd0;
    Ainvert = 1'b0;
    Binvert = 1'b0;
    cy_in   = 1'b0;
    e0      = '0;
    tick;
    tick;
    check_out("reset", e0, 1'b0, 1'b0);
    reset = 1'b0;
    tick;
    check_out("post_reset_idle", e0, 1'b0, 1'b0);

    run_alu("add_ovf", 3'd2, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_alu("sub_zero", 3'd2, 8'h05, 8'h05, 1'b0, 1'b1, 1'b1);
    run_alu("nor", 3'd0, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0);
    run_alu("nand", 3'd1, 8'hF0, 8'h0F, 1'b1, 1'b1, 1'b0);
    run_alu("slt_neg", 3'd3, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b1);
    run_alu("slt_pos", 3'd3, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0);
    run_alu("add_negovf", 3'd2, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_alu("reserved5", 3'd5, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
    run_mul("mul_200x3", 8'd200, 8'd3);
    chk("mul_200x3_const", 32'({result_hi, result}), 32'h0258);
    run_mul("mul_ffxff", 8'hFF, 8'hFF);
    run_mul("mul_zero", 8'h00, 8'h9C);

    // Back-to-back: a new start in the done cycle completes one cycle later
    e0    = model(3'd0, 8'hC3, 8'h5A, 1'b0, 1'b0, 1'b0);
    e1    = model(3'd2, 8'h10, 8'h22, 1'b0, 1'b0, 1'b1);
    op    = 3'd0;
    a     = 8'hC3;
    b     = 8'h5A;
    cy_in = 1'b0;
    start = 1'b1;
    tick;
    check_out("b2b_first", e0, 1'b1, 1'b0);
    op    = 3'd2;
    a     = 8'h10;
    b     = 8'h22;
    cy_in = 1'b1;
    tick;
    start = 1'b0;
    check_out("b2b_second", e1, 1'b1, 1'b0);
    tick;
    check_out("b2b_idle", e1, 1'b0, 1'b0);

    // Reset four cycles into a multiply aborts it with no done pulse
    op    = 3'd4;
    a     = 8'd200;
    b     = 8'd3;
    cy_in = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    reset = 1'b1;
    #1;
    e0 = '0;
    check_out("mul_abort", e0, 1'b0, 1'b0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("mul_abort_no_done", 32'(done), 32'd0);
    end
    run_alu("add_after_abort", 3'd2, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("add_after_abort_const", 32'(result), 32'h02);

    for (int i = 0; i < 30; i++) begin
      run_any("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
